// File: rtl/fp_mant_div_if.sv
// ---------------------------------------------------------------------------
// fp_mant_div_if
//   Handshake and data bundle between the operand unpacker, the mantissa
//   divider and the rounding/packing stage.
//
//   Parameters
//     MW : significand width (hidden bit included)
//     GR : extra quotient bits below the LSB (guard, round)
//
//   Signals (direction seen from the divider, i.e. the slave modport)
//     in_valid   in   operand pair valid
//     in_ready   out  divider can take a new pair
//     dividend   in   MW-bit numerator significand
//     divisor    in   MW-bit denominator significand
//     out_valid  out  result valid
//     out_ready  in   consumer takes the result
//     quotient   out  QW-bit quotient, bit QW-1 is the integer bit
//     remainder  out  MW-bit final non-negative remainder
//     sticky     out  remainder is non-zero
//     norm_shift out  dividend < divisor, exponent must drop by one
//     div_zero   out  divisor was zero
// ---------------------------------------------------------------------------
interface fp_mant_div_if #(
  parameter int MW = 24,
  parameter int GR = 2
);
  localparam int QW = MW + GR;

  logic          in_valid;
  logic          in_ready;
  logic [MW-1:0] dividend;
  logic [MW-1:0] divisor;
  logic          out_valid;
  logic          out_ready;
  logic [QW-1:0] quotient;
  logic [MW-1:0] remainder;
  logic          sticky;
  logic          norm_shift;
  logic          div_zero;

  // Producer/consumer side (unpacker feeding operands, packer taking results).
  modport master (
    output in_valid,
    output dividend,
    output divisor,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  quotient,
    input  remainder,
    input  sticky,
    input  norm_shift,
    input  div_zero
  );

  // Divider side.
  modport slave (
    input  in_valid,
    input  dividend,
    input  divisor,
    input  out_ready,
    output in_ready,
    output out_valid,
    output quotient,
    output remainder,
    output sticky,
    output norm_shift,
    output div_zero
  );
endinterface

// File: rtl/fp_mant_div.sv
// ---------------------------------------------------------------------------
// fp_mant_div
//   Radix-2 non-restoring significand divider for the floating-point divide
//   path. Accepts a pair of normalised significands, iterates one quotient
//   bit per cycle and presents quotient (with guard/round bits), remainder,
//   sticky, a one-bit normalisation shift and a divide-by-zero flag.
//
//   Result contract (X = dividend << norm_shift, D = divisor):
//     quotient  = floor(X * 2^(QW-1) / D)
//     remainder = X * 2^(QW-1) - quotient * D
//
//   Ports
//     clk   : rising-edge clock
//     rst   : synchronous active-high reset
//     flush : synchronous abort, drops the operation in flight
//     bus   : fp_mant_div_if slave modport (handshakes, operands, results)
//
//   Parameters
//     MW : significand width, hidden bit included
//     GR : guard/round bits below the quotient LSB
// ---------------------------------------------------------------------------
module fp_mant_div #(
  parameter int MW = 24,
  parameter int GR = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  fp_mant_div_if.slave bus
);

  localparam int QW = MW + GR;
  // The partial remainder is held at twice its true value (see below), so
  // it spans [-2D, 2D) with D < 2^MW; doubling before the add/subtract needs
  // one more bit plus the sign.
  localparam int PW = MW + 3;
  localparam int CW = $clog2(QW + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ITER = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_t;

  // Control and datapath state
  state_t               state_q, state_d;
  logic signed [PW-1:0] p_q, p_d;        // partial remainder, scaled by 2
  logic [MW:0]          d2_q, d2_d;      // registered divisor, scaled by 2
  logic [QW-1:0]        qacc_q, qacc_d;  // quotient bits shifted in MSB first
  logic [CW-1:0]        cnt_q, cnt_d;    // iterations still to run
  logic                 ns_q, ns_d;      // norm_shift captured at accept

  // Result registers
  logic                 out_valid_q, out_valid_d;
  logic [QW-1:0]        quotient_q, quotient_d;
  logic [MW-1:0]        remainder_q, remainder_d;
  logic                 sticky_q, sticky_d;
  logic                 norm_shift_q, norm_shift_d;
  logic                 div_zero_q, div_zero_d;

  // Combinational helpers
  logic                 accept;
  logic                 dvd_lt_dvs;
  logic [MW:0]          x_load;
  logic signed [PW-1:0] d2_s;
  logic signed [PW-1:0] p_shl;
  logic signed [PW-1:0] p_step;
  logic signed [PW-1:0] p_fixed;
  logic                 qbit;
  logic                 unused_p_bits;

  // flush wins over a simultaneous operand offer.
  assign accept     = bus.in_valid && (state_q == IDLE) && !flush;
  assign dvd_lt_dvs = bus.dividend < bus.divisor;
  assign x_load     = dvd_lt_dvs ? {bus.dividend, 1'b0} : {1'b0, bus.dividend};

  // Everything runs at 2x scale: loading P = X and using 2D makes the very
  // first "2P - 2D" equal to 2(X - D), which is the integer quotient step.
  // Without the scaling the first iteration would need a special case.
  assign d2_s  = $signed({{(PW-MW-1){1'b0}}, d2_q});
  assign p_shl = p_q <<< 1;

  always_comb begin
    p_step = p_shl - d2_s;
    if (p_q[PW-1]) begin
      p_step = p_shl + d2_s;
    end
  end

  // The quotient bit is the sign of the new partial remainder, which gives
  // the plain binary quotient directly (no signed-digit conversion needed).
  assign qbit = ~p_step[PW-1];

  // Final correction: a negative remainder gets the divisor added back.
  always_comb begin
    p_fixed = p_q;
    if (p_q[PW-1]) begin
      p_fixed = p_q + d2_s;
    end
  end

  // After correction p_fixed is 2*R with 0 <= R < D, so bit 0 is always zero
  // and the top bits are zero; only [MW:1] carries the remainder.
  assign unused_p_bits = ^{p_fixed[PW-1:MW+1], p_fixed[0]};

  // -------------------------------------------------------------------------
  // Next-state and datapath logic
  // -------------------------------------------------------------------------
  always_comb begin
    state_d      = state_q;
    p_d          = p_q;
    d2_d         = d2_q;
    qacc_d       = qacc_q;
    cnt_d        = cnt_q;
    ns_d         = ns_q;
    out_valid_d  = out_valid_q;
    quotient_d   = quotient_q;
    remainder_d  = remainder_q;
    sticky_d     = sticky_q;
    norm_shift_d = norm_shift_q;
    div_zero_d   = div_zero_q;

    case (state_q)
      IDLE: begin
        if (accept) begin
          ns_d   = dvd_lt_dvs;
          d2_d   = {bus.divisor, 1'b0};
          p_d    = $signed({{(PW-MW-1){1'b0}}, x_load});
          qacc_d = '0;
          cnt_d  = CW'(QW);
          if (bus.divisor == '0) begin
            // Zero divisor short-circuits straight to a saturated result.
            state_d      = DONE;
            out_valid_d  = 1'b1;
            quotient_d   = '1;
            remainder_d  = '0;
            sticky_d     = 1'b0;
            norm_shift_d = 1'b0;
            div_zero_d   = 1'b1;
          end else begin
            state_d = ITER;
          end
        end
      end

      ITER: begin
        p_d    = p_step;
        qacc_d = {qacc_q[QW-2:0], qbit};
        cnt_d  = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          state_d = FIX;
        end
      end

      FIX: begin
        quotient_d   = qacc_q;
        remainder_d  = p_fixed[MW:1];
        sticky_d     = |p_fixed[MW:1];
        norm_shift_d = ns_q;
        div_zero_d   = 1'b0;
        out_valid_d  = 1'b1;
        state_d      = DONE;
      end

      DONE: begin
        if (bus.out_ready) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    // Abort: back to IDLE, any held result is dropped, result regs untouched.
    if (flush) begin
      state_d     = IDLE;
      out_valid_d = 1'b0;
    end
  end

  // -------------------------------------------------------------------------
  // Registers
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      p_q          <= '0;
      d2_q         <= '0;
      qacc_q       <= '0;
      cnt_q        <= '0;
      ns_q         <= 1'b0;
      out_valid_q  <= 1'b0;
      quotient_q   <= '0;
      remainder_q  <= '0;
      sticky_q     <= 1'b0;
      norm_shift_q <= 1'b0;
      div_zero_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      p_q          <= p_d;
      d2_q         <= d2_d;
      qacc_q       <= qacc_d;
      cnt_q        <= cnt_d;
      ns_q         <= ns_d;
      out_valid_q  <= out_valid_d;
      quotient_q   <= quotient_d;
      remainder_q  <= remainder_d;
      sticky_q     <= sticky_d;
      norm_shift_q <= norm_shift_d;
      div_zero_q   <= div_zero_d;
    end
  end

  // -------------------------------------------------------------------------
  // Outputs
  // -------------------------------------------------------------------------
  assign bus.in_ready   = (state_q == IDLE);
  assign bus.out_valid  = out_valid_q;
  assign bus.quotient   = quotient_q;
  assign bus.remainder  = remainder_q;
  assign bus.sticky     = sticky_q;
  assign bus.norm_shift = norm_shift_q;
  assign bus.div_zero   = div_zero_q;

endmodule

// File: tb/tb_fp_mant_div.sv
// ---------------------------------------------------------------------------
// tb_fp_mant_div
//   Directed bench for fp_mant_div at MW=24 (default), MW=8 and MW=53.
//   Inputs are driven #1 after the rising edge and outputs sampled there too.
// ---------------------------------------------------------------------------
module tb_fp_mant_div;

  logic clk;
  logic rst;
  logic flush;
  int   checks;
  int   errors;

  fp_mant_div_if #(.MW(24), .GR(2)) bus   ();
  fp_mant_div_if #(.MW(8),  .GR(2)) bus8  ();
  fp_mant_div_if #(.MW(53), .GR(2)) bus53 ();

  fp_mant_div #(.MW(24), .GR(2)) dut   (.clk(clk), .rst(rst), .flush(flush), .bus(bus));
  fp_mant_div #(.MW(8),  .GR(2)) dut8  (.clk(clk), .rst(rst), .flush(flush), .bus(bus8));
  fp_mant_div #(.MW(53), .GR(2)) dut53 (.clk(clk), .rst(rst), .flush(flush), .bus(bus53));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus helpers (no checking inside) -----------------
  // Count edges after the accepting edge until out_valid is seen; 0 means
  // visible in the cycle right after accept, -1 means it never came.
  task automatic wait_res(output int lat);
    lat = 0;
    while (!bus.out_valid && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    if (!bus.out_valid) lat = -1;
  endtask

  task automatic do_op(input logic [23:0] a, input logic [23:0] b, output int lat);
    bus.dividend = a; bus.divisor = b; bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    wait_res(lat);
    $display("op24 a=%h b=%h q=%h r=%h st=%b ns=%b dz=%b lat=%0d",
             a, b, bus.quotient, bus.remainder, bus.sticky, bus.norm_shift, bus.div_zero, lat);
  endtask

  task automatic take24();
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
  endtask

  task automatic do_op8(input logic [7:0] a, input logic [7:0] b, output int lat);
    bus8.dividend = a; bus8.divisor = b; bus8.in_valid = 1'b1;
    @(posedge clk); #1;
    bus8.in_valid = 1'b0;
    lat = 0;
    while (!bus8.out_valid && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    if (!bus8.out_valid) lat = -1;
    $display("op8 a=%h b=%h q=%h r=%h st=%b ns=%b lat=%0d",
             a, b, bus8.quotient, bus8.remainder, bus8.sticky, bus8.norm_shift, lat);
    bus8.out_ready = 1'b1;
    @(posedge clk); #1;
    bus8.out_ready = 1'b0;
  endtask

  // Captures the result before releasing it.
  task automatic do_op53(input logic [52:0] a, input logic [52:0] b, output int lat,
                         output logic [54:0] q, output logic [52:0] r,
                         output logic st, output logic ns);
    bus53.dividend = a; bus53.divisor = b; bus53.in_valid = 1'b1;
    @(posedge clk); #1;
    bus53.in_valid = 1'b0;
    lat = 0;
    while (!bus53.out_valid && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
    if (!bus53.out_valid) lat = -1;
    q = bus53.quotient; r = bus53.remainder; st = bus53.sticky; ns = bus53.norm_shift;
    $display("op53 a=%h b=%h q=%h r=%h lat=%0d", a, b, q, r, lat);
    bus53.out_ready = 1'b1;
    @(posedge clk); #1;
    bus53.out_ready = 1'b0;
  endtask

  // ------------------------------- tests ----------------------------------
  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got=%b want=1", bus.in_ready); end
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b want=0", bus.out_valid); end
    checks++; if (bus.quotient !== 26'h0) begin errors++; $display("FAIL reset_quotient got=%h want=0", bus.quotient); end
    checks++; if (bus.remainder !== 24'h0) begin errors++; $display("FAIL reset_remainder got=%h want=0", bus.remainder); end
    checks++; if ({bus.sticky, bus.norm_shift, bus.div_zero} !== 3'b000) begin
      errors++; $display("FAIL reset_flags got=%b want=000", {bus.sticky, bus.norm_shift, bus.div_zero}); end
    checks++; if (bus8.in_ready !== 1'b1 || bus53.in_ready !== 1'b1) begin
      errors++; $display("FAIL reset_other_ready got=%b%b want=11", bus8.in_ready, bus53.in_ready); end
  endtask

  task automatic test_basic();
    int lat;
    do_op(24'h800000, 24'hC00000, lat);
    checks++; if (lat !== 27) begin errors++; $display("FAIL basic_latency got=%0d want=27", lat); end
    checks++; if (bus.quotient !== 26'h2AAAAAA) begin errors++; $display("FAIL basic_quotient got=%h want=2aaaaaa", bus.quotient); end
    checks++; if (bus.remainder !== 24'h800000) begin errors++; $display("FAIL basic_remainder got=%h want=800000", bus.remainder); end
    checks++; if ({bus.sticky, bus.norm_shift, bus.div_zero} !== 3'b110) begin
      errors++; $display("FAIL basic_flags got=%b want=110", {bus.sticky, bus.norm_shift, bus.div_zero}); end
    checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL basic_in_ready_done got=%b want=0", bus.in_ready); end
    take24();
    checks++; if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
      errors++; $display("FAIL basic_handshake got ov=%b ir=%b want ov=0 ir=1", bus.out_valid, bus.in_ready); end
    checks++; if (bus.quotient !== 26'h2AAAAAA) begin errors++; $display("FAIL basic_hold_after got=%h want=2aaaaaa", bus.quotient); end
  endtask

  task automatic test_exact();
    int lat;
    do_op(24'hC00000, 24'h800000, lat);
    checks++; if (bus.quotient !== 26'h3000000) begin errors++; $display("FAIL exact_quotient got=%h want=3000000", bus.quotient); end
    checks++; if (bus.remainder !== 24'h0) begin errors++; $display("FAIL exact_remainder got=%h want=0", bus.remainder); end
    checks++; if ({bus.sticky, bus.norm_shift} !== 2'b00) begin errors++; $display("FAIL exact_flags got=%b want=00", {bus.sticky, bus.norm_shift}); end
    take24();
    do_op(24'h800000, 24'h800000, lat);
    checks++; if (bus.quotient !== 26'h2000000) begin errors++; $display("FAIL equal_quotient got=%h want=2000000", bus.quotient); end
    checks++; if ({bus.sticky, bus.norm_shift} !== 2'b00) begin errors++; $display("FAIL equal_flags got=%b want=00", {bus.sticky, bus.norm_shift}); end
    checks++; if (lat !== 27) begin errors++; $display("FAIL equal_latency got=%0d want=27", lat); end
    take24();
  endtask

  task automatic test_div_zero();
    int lat;
    do_op(24'h9ABCDE, 24'h000000, lat);
    // Zero divisor: result visible in the cycle right after accept.
    checks++; if (lat !== 0) begin errors++; $display("FAIL dz_latency got=%0d want=0", lat); end
    checks++; if (bus.div_zero !== 1'b1) begin errors++; $display("FAIL dz_flag got=%b want=1", bus.div_zero); end
    checks++; if (bus.quotient !== 26'h3FFFFFF) begin errors++; $display("FAIL dz_quotient got=%h want=3ffffff", bus.quotient); end
    checks++; if (bus.remainder !== 24'h0 || bus.sticky !== 1'b0 || bus.norm_shift !== 1'b0) begin
      errors++; $display("FAIL dz_rest got r=%h st=%b ns=%b want 0 0 0", bus.remainder, bus.sticky, bus.norm_shift); end
    take24();
  endtask

  task automatic test_back_to_back();
    int lat;
    do_op(24'h800000, 24'hC00000, lat);
    checks++; if (bus.quotient !== 26'h2AAAAAA) begin errors++; $display("FAIL b2b_quotient got=%h want=2aaaaaa", bus.quotient); end
    checks++; if (bus.div_zero !== 1'b0) begin errors++; $display("FAIL b2b_div_zero got=%b want=0", bus.div_zero); end
    checks++; if (lat !== 27) begin errors++; $display("FAIL b2b_latency got=%0d want=27", lat); end
    take24();
  endtask

  task automatic test_backpressure();
    int lat;
    do_op(24'h800000, 24'hC00000, lat);
    // Offer a new pair while the result is held.
    bus.dividend = 24'hC00000; bus.divisor = 24'h800000; bus.in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      checks++; if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0) begin
        errors++; $display("FAIL bp_hold_%0d got ov=%b ir=%b want ov=1 ir=0", i, bus.out_valid, bus.in_ready); end
      checks++; if (bus.quotient !== 26'h2AAAAAA || bus.sticky !== 1'b1) begin
        errors++; $display("FAIL bp_stable_%0d got q=%h st=%b want q=2aaaaaa st=1", i, bus.quotient, bus.sticky); end
    end
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    checks++; if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
      errors++; $display("FAIL bp_release got ov=%b ir=%b want ov=0 ir=1", bus.out_valid, bus.in_ready); end
    @(posedge clk); #1;   // pending pair accepted here
    bus.in_valid = 1'b0;
    checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL bp_accept got ir=%b want 0", bus.in_ready); end
    wait_res(lat);
    checks++; if (lat !== 27) begin errors++; $display("FAIL bp_pending_latency got=%0d want=27", lat); end
    checks++; if (bus.quotient !== 26'h3000000) begin errors++; $display("FAIL bp_pending_quotient got=%h want=3000000", bus.quotient); end
    $display("op24 pending q=%h lat=%0d", bus.quotient, lat);
    take24();
  endtask

  task automatic test_flush_reset();
    int lat;
    int seen;
    // flush at ITER cycle 5
    bus.dividend = 24'h800000; bus.divisor = 24'hC00000; bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1 flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    checks++; if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
      errors++; $display("FAIL flush_iter got ir=%b ov=%b want ir=1 ov=0", bus.in_ready, bus.out_valid); end
    seen = 0;
    repeat (30) begin @(posedge clk); #1; if (bus.out_valid) seen = 1; end
    checks++; if (seen !== 0) begin errors++; $display("FAIL flush_no_result got=%0d want=0", seen); end
    checks++; if (bus.quotient !== 26'h3000000) begin errors++; $display("FAIL flush_regs_kept got=%h want=3000000", bus.quotient); end
    // rst at ITER cycle 12
    bus.dividend = 24'hC00000; bus.divisor = 24'h800000; bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    repeat (11) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    checks++; if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
      errors++; $display("FAIL rst_iter got ir=%b ov=%b want ir=1 ov=0", bus.in_ready, bus.out_valid); end
    checks++; if (bus.quotient !== 26'h0) begin errors++; $display("FAIL rst_clears_quotient got=%h want=0", bus.quotient); end
    do_op(24'h800000, 24'hC00000, lat);
    checks++; if (bus.quotient !== 26'h2AAAAAA || lat !== 27) begin
      errors++; $display("FAIL after_rst got q=%h lat=%0d want q=2aaaaaa lat=27", bus.quotient, lat); end
    take24();
    // flush while a result is held in DONE
    do_op(24'h800000, 24'h000000, lat);
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    checks++; if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
      errors++; $display("FAIL flush_done got ov=%b ir=%b want ov=0 ir=1", bus.out_valid, bus.in_ready); end
    checks++; if (bus.quotient !== 26'h3FFFFFF || bus.div_zero !== 1'b1) begin
      errors++; $display("FAIL flush_done_kept got q=%h dz=%b want 3ffffff 1", bus.quotient, bus.div_zero); end
    // flush together with in_valid in IDLE: nothing accepted
    bus.dividend = 24'hC00000; bus.divisor = 24'h800000; bus.in_valid = 1'b1; flush = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0; flush = 1'b0;
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL flush_wins got ir=%b want 1", bus.in_ready); end
    @(posedge clk); #1;
    checks++; if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
      errors++; $display("FAIL flush_wins_idle got ov=%b ir=%b want 0 1", bus.out_valid, bus.in_ready); end
  endtask

  task automatic test_mw8();
    int lat;
    logic [7:0]  a, b;
    logic [8:0]  x;
    logic [31:0] num, qm, rm;
    // Hand-computed: 0x80/0xC0 -> X=256, q=floor(256*512/192)=682, r=128
    do_op8(8'h80, 8'hC0, lat);
    checks++; if (bus8.quotient !== 10'h2AA || bus8.remainder !== 8'd128 || lat !== 11) begin
      errors++; $display("FAIL mw8_a got q=%h r=%0d lat=%0d want q=2aa r=128 lat=11", bus8.quotient, bus8.remainder, lat); end
    checks++; if ({bus8.sticky, bus8.norm_shift} !== 2'b11) begin errors++; $display("FAIL mw8_a_flags got=%b want=11", {bus8.sticky, bus8.norm_shift}); end
    // 0xFF/0x80 -> q=255*512/128=1020, r=0
    do_op8(8'hFF, 8'h80, lat);
    checks++; if (bus8.quotient !== 10'h3FC || bus8.remainder !== 8'd0 || bus8.sticky !== 1'b0) begin
      errors++; $display("FAIL mw8_b got q=%h r=%0d st=%b want q=3fc r=0 st=0", bus8.quotient, bus8.remainder, bus8.sticky); end
    // 0x90/0xF0 -> X=288, q=floor(288*512/240)=614, r=96
    do_op8(8'h90, 8'hF0, lat);
    checks++; if (bus8.quotient !== 10'h266 || bus8.remainder !== 8'd96) begin
      errors++; $display("FAIL mw8_c got q=%h r=%0d want q=266 r=96", bus8.quotient, bus8.remainder); end
    for (int i = 0; i < 12; i++) begin
      a = 8'($urandom_range(128, 255));
      b = 8'($urandom_range(128, 255));
      x = (a < b) ? {a, 1'b0} : {1'b0, a};
      num = {23'd0, x} << 9;
      qm = num / {24'd0, b};
      rm = num - qm * {24'd0, b};
      bus8.dividend = a; bus8.divisor = b; bus8.in_valid = 1'b1;
      @(posedge clk); #1;
      bus8.in_valid = 1'b0;
      lat = 0;
      while (!bus8.out_valid && lat < 100) begin @(posedge clk); #1; lat++; end
      if (!bus8.out_valid) lat = -1;
      $display("op8 a=%h b=%h q=%h r=%h lat=%0d", a, b, bus8.quotient, bus8.remainder, lat);
      checks++; if (bus8.quotient !== qm[9:0] || bus8.remainder !== rm[7:0] || lat !== 11) begin
        errors++; $display("FAIL mw8_rand_%0d got q=%h r=%h lat=%0d want q=%h r=%h lat=11", i, bus8.quotient, bus8.remainder, lat, qm[9:0], rm[7:0]); end
      checks++; if (bus8.quotient[9] !== 1'b1 || bus8.sticky !== (rm != 0) || bus8.norm_shift !== (a < b)) begin
        errors++; $display("FAIL mw8_rand_flags_%0d got msb=%b st=%b ns=%b want 1 %b %b", i, bus8.quotient[9], bus8.sticky, bus8.norm_shift, rm != 0, a < b); end
      bus8.out_ready = 1'b1;
      @(posedge clk); #1;
      bus8.out_ready = 1'b0;
    end
  endtask

  task automatic test_mw53();
    int           lat;
    logic [52:0]  a, b, r;
    logic [54:0]  q;
    logic         st, ns;
    logic [127:0] num, dd, qm, rm;
    for (int i = 0; i < 5; i++) begin
      if (i == 0) begin
        a = 53'h10000000000000;   // 2^52
        b = 53'h18000000000000;   // 1.5 * 2^52
      end else begin
        a = {1'b1, 20'($urandom), 32'($urandom)};
        b = {1'b1, 20'($urandom), 32'($urandom)};
      end
      num = (a < b) ? ({75'd0, a} << 1) : {75'd0, a};
      num = num << 54;
      dd  = {75'd0, b};
      qm  = num / dd;
      rm  = num - qm * dd;
      do_op53(a, b, lat, q, r, st, ns);
      checks++; if (q !== qm[54:0] || r !== rm[52:0]) begin
        errors++; $display("FAIL mw53_%0d got q=%h r=%h want q=%h r=%h", i, q, r, qm[54:0], rm[52:0]); end
      checks++; if (lat !== 56 || q[54] !== 1'b1 || st !== (rm != 0) || ns !== (a < b)) begin
        errors++; $display("FAIL mw53_meta_%0d got lat=%0d msb=%b st=%b ns=%b want 56 1 %b %b", i, lat, q[54], st, ns, rm != 0, a < b); end
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1;
    flush = 1'b0;
    bus.in_valid = 1'b0;   bus.out_ready = 1'b0;   bus.dividend = '0;   bus.divisor = '0;
    bus8.in_valid = 1'b0;  bus8.out_ready = 1'b0;  bus8.dividend = '0;  bus8.divisor = '0;
    bus53.in_valid = 1'b0; bus53.out_ready = 1'b0; bus53.dividend = '0; bus53.divisor = '0;
    test_reset();
    test_basic();
    test_exact();
    test_div_zero();
    test_back_to_back();
    test_backpressure();
    test_flush_reset();
    test_mw8();
    test_mw53();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
